sram_responder: RTL and testbench
=================================

// Module: sram_responder
// PURPOSE
//  Memory-side responder for the IFU/LSU fetch/load/store handshake. It accepts one request
//  (valid/ready), waits a fixed or pseudo-random number of cycles, then performs exactly one
//  DPI-C access (paddr_read or paddr_write). It holds the result on a response channel
//  (valid/ready). It sits between the core's memory initiators and the simulated physical memory.
// PARAMETERS
//  ADDR_W        32     request address width
//  DATA_W        32     read/write data width
//  FIXED_LAT     0      0 = LFSR-random latency; N>=1 = fixed N-cycle latency
//  LAT_LOG2      3      number of LFSR bits used for random latency (range 1..2^LAT_LOG2)
//  LFSR_SEED     8'hA5  LFSR reset value; must be non-zero
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       asynchronous reset, active-high
//  req_valid   in   1       initiator presents a request
//  req_ready   out  1       responder can accept a request
//  req_addr    in   ADDR_W  byte address
//  req_wen     in   1       1 = write, 0 = read
//  req_wdata   in   DATA_W  write data
//  req_wmask   in   4       byte-lane write strobe
//  resp_valid  out  1       response available
//  resp_ready  in   1       initiator accepts the response
//  resp_rdata  out  DATA_W  read data (0 for writes)
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, cnt=0, lfsr=LFSR_SEED.
//  - The LFSR is 8-bit Galois (x^8+x^6+x^5+x^4+1). It advances every cycle out of reset.
//  - IDLE: req_ready=1. On req_valid&req_ready, latch addr/wen/wdata/wmask. Load cnt with
//    FIXED_LAT-1 if FIXED_LAT!=0, else lfsr[LAT_LOG2-1:0]. Go to WAIT.
//  - WAIT: req_ready=0. Decrement cnt each cycle. On the cycle with cnt==0, perform the access:
//    - read: paddr_read({addr[31:2],2'b00}) and register the result into resp_rdata.
//    - write: paddr_write(addr,wdata,{4'b0,wmask}), resp_rdata=0. wmask==0 makes no DPI call.
//    Then go to RESP with resp_valid=1.
//  - Latency: resp_valid rises exactly cnt_loaded+1 cycles after the accept edge (FIXED_LAT=N -> N cycles).
//  - RESP: resp_valid=1. resp_rdata is held stable until resp_valid&resp_ready. req_ready=0.
//    On the handshake: resp_valid=0 and go to IDLE. The next accept is possible one cycle later
//    (no same-cycle turnaround).
//  - req_valid while req_ready=0 is ignored; nothing is latched and no request is lost on the
//    responder side, because the initiator holds valid.
//  - Request fields may change after accept without effect, since they are latched.
//  - Each accepted request produces exactly one DPI call and exactly one response.
//  - Reset mid-WAIT abandons the request with no DPI call.
//  - Reset in RESP drops resp_valid immediately.
//  - cnt is LAT_LOG2 bits wide (fixed mode: ceil(log2(FIXED_LAT)) bits, minimum 1). No wrap is
//    possible because it only decrements toward 0.
//  - FSM encoding: IDLE=2'd0, WAIT=2'd1, RESP=2'd2. 2'd3 is illegal and recovers to IDLE.
// STRUCTURE
//  - Shared header mem_if_defs.vh holds the state encodings, LFSR tap mask and DPI import
//    declarations (imported once for the whole design).
//  - One sub-module, lfsr8 (clk, rst, seed, out[7:0]). It is reused by future random-delay
//    arbiters and ready generators.
//  - All remaining logic (FSM, cnt, latch registers, DPI calls) lives in this module. The DPI
//    calls sit inside the clocked always block at the WAIT->RESP transition.
// TESTING
//  1. FIXED_LAT=1, read 0x80000000 (mem=0x00000413), resp_ready=1 -> resp_valid 1 cycle after
//     accept, rdata=0x00000413, req_ready back 1 cycle after response handshake.
//  2. FIXED_LAT=3, write addr=0x80000100, wdata=0xDEADBEEF, wmask=4'b0011 -> exactly 1
//     paddr_write(mask 8'h03) at cycle 3; a following read returns 0x????BEEF with upper bytes preserved.
//  3. Backpressure: resp_ready=0 for 5 cycles -> resp_valid and rdata held constant. The DPI
//     call count stays 1, and no new request is accepted until the handshake.
//  4. Random latency, LFSR_SEED=8'hA5, 100 back-to-back reads -> every latency lies in 1..8,
//     the sequence matches the reference LFSR model, and 100 responses are returned in order.
//  5. Reset asserted 1 cycle into WAIT -> no DPI call, resp_valid=0, req_ready=1 asynchronously;
//     the next request completes normally.
//  6. Write with wmask=4'b0000 -> no DPI call, response still returned, rdata=0.

Source files
------------

// File: rtl/sram_responder_pkg.sv
// Shared types for the SRAM responder: FSM state encoding and the LFSR step function.
package sram_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Galois taps for x^8+x^6+x^5+x^4+1 in right-shift form
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
    return {1'b0, cur[7:1]} ^ (cur[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/sram_responder_if.sv
// Request/response handshake plus the memory access port that stands in for the DPI-C memory calls.
interface sram_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_wen;
  logic [DATA_W-1:0] req_wdata;
  logic [3:0]        req_wmask;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;

  // One mem_en pulse per memory access, sampled on the WAIT->RESP edge
  logic              mem_en;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [7:0]        mem_wmask;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata,
           mem_en, mem_wen, mem_addr, mem_wdata, mem_wmask
  );

  modport memory (
    input  mem_en, mem_wen, mem_addr, mem_wdata, mem_wmask,
    output mem_rdata
  );
endinterface

// File: rtl/sram_responder_lfsr8.sv
// 8-bit Galois LFSR, loaded from seed on reset and advancing every cycle afterwards.
module lfsr8
  import sram_responder_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seed,
  output logic [7:0] out
);

  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_step(lfsr_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= seed;
    else     lfsr_q <= lfsr_d;
  end

  assign out = lfsr_q;

endmodule

// File: rtl/sram_responder.sv
// Memory-side responder: accept one request, wait a fixed or LFSR-random delay,
// perform exactly one memory access, then hold the response until it is taken.
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int         ADDR_W    = 32,
  parameter int         DATA_W    = 32,
  parameter int         FIXED_LAT = 0,
  parameter int         LAT_LOG2  = 3,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input logic              clk,
  input logic              rst,
  sram_responder_if.slave  bus
);

  localparam int FIX_W = (FIXED_LAT > 1) ? $clog2(FIXED_LAT) : 1;
  localparam int CNT_W = (FIXED_LAT != 0) ? FIX_W : LAT_LOG2;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wmask_q, wmask_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

  logic [7:0]        lfsr_out;
  logic              lfsr_unused;
  logic [CNT_W-1:0]  cnt_load;
  logic              mem_en;

  lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .out  (lfsr_out)
  );

  // Only the low LAT_LOG2 bits pick the delay; the rest of the state is kept for its period
  assign lfsr_unused = ^lfsr_out;

  if (FIXED_LAT != 0) begin : g_fixed
    assign cnt_load = CNT_W'(FIXED_LAT - 1);
  end else begin : g_random
    assign cnt_load = lfsr_out[CNT_W-1:0];
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    mem_en       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
        if (bus.req_valid && req_ready_q) begin
          addr_d      = bus.req_addr;
          wen_d       = bus.req_wen;
          wdata_d     = bus.req_wdata;
          wmask_d     = bus.req_wmask;
          cnt_d       = cnt_load;
          req_ready_d = 1'b0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          // An all-zero write strobe still responds but never touches memory
          mem_en       = !wen_q || (wmask_q != 4'b0000);
          resp_rdata_d = wen_q ? '0 : bus.mem_rdata;
          resp_valid_d = 1'b1;
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (resp_valid_q && bus.resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_en     = mem_en;
  assign bus.mem_wen    = wen_q;
  assign bus.mem_addr   = wen_q ? addr_q : {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_wmask  = {4'b0000, wmask_q};

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder: three instances (latency 1, latency 3, random) share one memory model.
module tb_sram_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_responder_if #(.ADDR_W(32), .DATA_W(32)) b0 ();
  sram_responder_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
  sram_responder_if #(.ADDR_W(32), .DATA_W(32)) b2 ();

  sram_responder #(.ADDR_W(32), .DATA_W(32), .FIXED_LAT(1), .LAT_LOG2(3), .LFSR_SEED(8'hA5))
    u_lat1 (.clk(clk), .rst(rst), .bus(b0.slave));
  sram_responder #(.ADDR_W(32), .DATA_W(32), .FIXED_LAT(3), .LAT_LOG2(3), .LFSR_SEED(8'hA5))
    u_lat3 (.clk(clk), .rst(rst), .bus(b1.slave));
  sram_responder #(.ADDR_W(32), .DATA_W(32), .FIXED_LAT(0), .LAT_LOG2(3), .LFSR_SEED(8'hA5))
    u_rnd  (.clk(clk), .rst(rst), .bus(b2.slave));

  int          sel;
  logic        req_valid, req_wen, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wmask;
  logic [31:0] mem [256];

  assign b0.req_valid = req_valid && (sel == 0);
  assign b1.req_valid = req_valid && (sel == 1);
  assign b2.req_valid = req_valid && (sel == 2);
  assign b0.resp_ready = resp_ready;
  assign b1.resp_ready = resp_ready;
  assign b2.resp_ready = resp_ready;
  assign b0.req_addr = req_addr;  assign b1.req_addr = req_addr;  assign b2.req_addr = req_addr;
  assign b0.req_wen = req_wen;    assign b1.req_wen = req_wen;    assign b2.req_wen = req_wen;
  assign b0.req_wdata = req_wdata; assign b1.req_wdata = req_wdata; assign b2.req_wdata = req_wdata;
  assign b0.req_wmask = req_wmask; assign b1.req_wmask = req_wmask; assign b2.req_wmask = req_wmask;
  assign b0.mem_rdata = mem[b0.mem_addr[9:2]];
  assign b1.mem_rdata = mem[b1.mem_addr[9:2]];
  assign b2.mem_rdata = mem[b2.mem_addr[9:2]];

  logic        req_ready, resp_valid, mem_en, mem_wen;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;

  always_comb begin
    case (sel)
      0: begin
        req_ready = b0.req_ready; resp_valid = b0.resp_valid; resp_rdata = b0.resp_rdata;
        mem_en = b0.mem_en; mem_wen = b0.mem_wen; mem_addr = b0.mem_addr;
        mem_wdata = b0.mem_wdata; mem_wmask = b0.mem_wmask;
      end
      1: begin
        req_ready = b1.req_ready; resp_valid = b1.resp_valid; resp_rdata = b1.resp_rdata;
        mem_en = b1.mem_en; mem_wen = b1.mem_wen; mem_addr = b1.mem_addr;
        mem_wdata = b1.mem_wdata; mem_wmask = b1.mem_wmask;
      end
      default: begin
        req_ready = b2.req_ready; resp_valid = b2.resp_valid; resp_rdata = b2.resp_rdata;
        mem_en = b2.mem_en; mem_wen = b2.mem_wen; mem_addr = b2.mem_addr;
        mem_wdata = b2.mem_wdata; mem_wmask = b2.mem_wmask;
      end
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference LFSR written bit-by-bit from the polynomial
  logic [7:0] lfsr_m;
  always @(posedge clk or posedge rst) begin
    if (rst) lfsr_m <= 8'hA5;
    else     lfsr_m <= {lfsr_m[0], lfsr_m[7], lfsr_m[6] ^ lfsr_m[0], lfsr_m[5] ^ lfsr_m[0],
                        lfsr_m[4] ^ lfsr_m[0], lfsr_m[3], lfsr_m[2], lfsr_m[1]};
  end

  function automatic logic [31:0] pat(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0001_0003;
  endfunction

  int         calls = 0;
  int         call_cyc = 0;
  logic [7:0] last_mask = 8'h00;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = pat(i);
    mem[0]  = 32'h0000_0413;
    mem[64] = 32'h1234_5678;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        calls++;
        call_cyc = cyc + 1;
        last_mask = mem_wmask;
        if (mem_wen)
          for (int k = 0; k < 4; k++)
            if (mem_wmask[k]) mem[mem_addr[9:2]][8*k +: 8] = mem_wdata[8*k +: 8];
      end
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    int          lat;
    int          acc;
  } exp_t;
  exp_t q[$];
  int   last_acc = 0;

  logic prev_v = 1'b0;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst) prev_v = 1'b0;
    else begin
      if (resp_valid && !prev_v) begin
        if (q.size() == 0) chk("unexpected_resp", 64'd1, 64'd0);
        else begin
          e = q.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_latency", 64'(cyc - e.acc), 64'(e.lat));
        end
      end
      prev_v = resp_valid;
    end
  end

  // exp_lat < 0 means the random latency comes from the reference LFSR
  task automatic do_req(input logic [31:0] a, input logic w, input logic [31:0] wd,
                        input logic [3:0] m, input logic [31:0] exp_rd, input int exp_lat);
    exp_t e;
    int   n;
    req_addr = a; req_wen = w; req_wdata = wd; req_wmask = m; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin
      chk("req_ready_timeout", 64'd0, 64'd1);
      req_valid = 1'b0;
      return;
    end
    e.rdata = exp_rd;
    e.lat   = (exp_lat < 0) ? int'(lfsr_m[2:0]) + 1 : exp_lat;
    e.acc   = cyc + 1;
    last_acc = e.acc;
    q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFC; req_wen = ~w;
    req_wdata = 32'h0BAD_0BAD; req_wmask = 4'hF;
  endtask

  task automatic wait_resp(input string nm);
    int n = 0;
    while (!resp_valid && n < 30) begin @(posedge clk); #1; n++; end
    if (!resp_valid) chk(nm, 64'd0, 64'd1);
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while ((q.size() != 0 || !req_ready) && n < 100) begin @(posedge clk); #1; n++; end
    chk(nm, 64'((q.size() == 0) && req_ready), 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int c0;
    rst = 1'b1; sel = 0; req_valid = 1'b0; req_wen = 1'b0; resp_ready = 1'b1;
    req_addr = '0; req_wdata = '0; req_wmask = '0;
    #12;
    chk("reset_lat1", {b0.req_ready, b0.resp_valid, b0.resp_rdata}, {1'b1, 1'b0, 32'h0});
    chk("reset_lat3", {b1.req_ready, b1.resp_valid, b1.resp_rdata}, {1'b1, 1'b0, 32'h0});
    chk("reset_rnd",  {b2.req_ready, b2.resp_valid, b2.resp_rdata}, {1'b1, 1'b0, 32'h0});
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // Latency-1 read, then req_ready returns one cycle after the handshake
    sel = 0;
    do_req(32'h8000_0000, 1'b0, 32'h0, 4'h0, 32'h0000_0413, 1);
    wait_resp("t1_resp_timeout");
    @(posedge clk); #1;
    chk("t1_after_hs", {req_ready, resp_valid}, 2'b10);

    // Latency-3 partial write followed by a read-back
    sel = 1;
    c0 = calls;
    do_req(32'h8000_0100, 1'b1, 32'hDEAD_BEEF, 4'b0011, 32'h0, 3);
    wait_drain("t2_drain_w");
    chk("t2_calls", 64'(calls - c0), 64'd1);
    chk("t2_mask", last_mask, 8'h03);
    chk("t2_call_cycle", 64'(call_cyc - last_acc), 64'd3);
    do_req(32'h8000_0100, 1'b0, 32'h0, 4'h0, 32'h1234_BEEF, 3);
    wait_drain("t2_drain_r");

    // Backpressure with a competing write request held on the bus
    sel = 0;
    resp_ready = 1'b0;
    c0 = calls;
    do_req(32'h8000_0000, 1'b0, 32'h0, 4'h0, 32'h0000_0413, 1);
    wait_resp("t3_resp_timeout");
    req_addr = 32'h8000_0000; req_wen = 1'b1; req_wdata = 32'hFFFF_FFFF; req_wmask = 4'hF;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t3_hold", {resp_valid, req_ready, resp_rdata}, {1'b1, 1'b0, 32'h0000_0413});
    end
    chk("t3_calls", 64'(calls - c0), 64'd1);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("t3_release", {resp_valid, req_ready}, 2'b01);
    do_req(32'h8000_0002, 1'b0, 32'h0, 4'h0, 32'h0000_0413, 1);
    wait_drain("t3_drain");

    // Zero-strobe write: response returned, memory untouched
    sel = 1;
    c0 = calls;
    do_req(32'h8000_0100, 1'b1, 32'hFFFF_FFFF, 4'b0000, 32'h0, 3);
    wait_drain("t6_drain");
    chk("t6_calls", 64'(calls - c0), 64'd0);
    do_req(32'h8000_0100, 1'b0, 32'h0, 4'h0, 32'h1234_BEEF, 3);
    wait_drain("t6_drain_r");

    // Reset one cycle into WAIT abandons the request
    c0 = calls;
    req_addr = 32'h8000_0000; req_wen = 1'b0; req_wmask = 4'h0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t5_async", {req_ready, resp_valid}, 2'b10);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    chk("t5_no_call", 64'(calls - c0), 64'd0);
    chk("t5_no_resp", {63'd0, resp_valid}, 64'd0);
    do_req(32'h8000_0004, 1'b0, 32'h0, 4'h0, pat(1), 3);
    wait_drain("t5_drain");

    // 100 back-to-back reads with LFSR-driven latency
    sel = 2;
    c0 = calls;
    for (int i = 0; i < 100; i++)
      do_req(32'h8000_0000 + 32'(4 * (100 + i)) + 32'(i % 4), 1'b0, 32'h0, 4'h0, pat(100 + i), -1);
    wait_drain("t4_drain");
    chk("t4_calls", 64'(calls - c0), 64'd100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
